// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Package : hazard_scoreboard_pkg
// Brief   : Shared types and constants for the hazard scoreboard slice.
// Rev     : 1.0
// ============================================================================
package hazard_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DEF_NFWD   = 2;
  localparam int DEF_LAT_W  = 4;

  // Forward-select code meaning "read from the register file".
  localparam int FW_SEL_RF = 0;

  typedef logic [REG_ADDR_W-1:0]        reg_addr_t;
  typedef logic [$clog2(DEF_NFWD+1)-1:0] fw_sel_t;
  typedef logic [DEF_LAT_W-1:0]          sb_lat_t;

  function automatic int fw_sel_width(input int nfwd);
    return (nfwd > 0) ? $clog2(nfwd + 1) : 1;
  endfunction

  function automatic int reg_idx_width(input int nregs);
    return (nregs > 2) ? $clog2(nregs) : 1;
  endfunction

endpackage : hazard_scoreboard_pkg
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Interface : hazard_scoreboard_if
// Brief     : Pipeline-side bundle between ID/EX/bypass/WB and the scoreboard.
// Rev       : 1.0
// ============================================================================
interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int LAT_W  = 4,
  parameter int SCNT_W = 32
);

  localparam int FSW = fw_sel_width(NFWD);

  logic [NSRC-1:0]            src_valid;
  reg_addr_t [NSRC-1:0]       src_addr;
  logic                       issue_valid;
  logic                       issue_we;
  reg_addr_t                  issue_rd;
  logic [LAT_W-1:0]           issue_lat;
  logic [NFWD-1:0]            fw_valid;
  reg_addr_t [NFWD-1:0]       fw_rd;
  logic                       wb_valid;
  reg_addr_t                  wb_rd;
  logic                       br_true;

  logic                       stall;
  logic                       bubble_ex;
  logic                       flush_if;
  logic                       flush_id;
  logic [NSRC-1:0][FSW-1:0]   fw_sel;
  logic [SCNT_W-1:0]          stall_cnt;

  modport master (
    output src_valid, src_addr, issue_valid, issue_we, issue_rd, issue_lat,
    output fw_valid, fw_rd, wb_valid, wb_rd, br_true,
    input  stall, bubble_ex, flush_if, flush_id, fw_sel, stall_cnt
  );

  modport slave (
    input  src_valid, src_addr, issue_valid, issue_we, issue_rd, issue_lat,
    input  fw_valid, fw_rd, wb_valid, wb_rd, br_true,
    output stall, bubble_ex, flush_if, flush_id, fw_sel, stall_cnt
  );

endinterface : hazard_scoreboard_if
`default_nettype wire

// File: rtl/hazard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module : hazard_sb_entry
// Brief  : Pending flag plus forwardability countdown for one register.
// Rev    : 1.0
// ============================================================================
module hazard_sb_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [LAT_W-1:0] lat,
  output logic             pending,
  output logic [LAT_W-1:0] cnt
);

  logic             r_pending;
  logic [LAT_W-1:0] r_cnt;

  // A new issue takes priority over a writeback that lands in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= 1'b0;
      r_cnt     <= '0;
    end else if (load) begin
      r_pending <= 1'b1;
      r_cnt     <= lat;
    end else begin
      if (clear) begin
        r_pending <= 1'b0;
      end
      if (r_pending && (r_cnt != '0)) begin
        r_cnt <= r_cnt - LAT_W'(1);
      end
    end
  end

  assign pending = r_pending;
  assign cnt     = r_cnt;

endmodule : hazard_sb_entry
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Per-register in-flight tracking, stall/flush and bypass selection.
// Rev    : 1.0
// ============================================================================
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NSRC   = 2,
  parameter int NFWD   = 2,
  parameter int LAT_W  = 4,
  parameter int SCNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave sb
);

  localparam int AW  = reg_idx_width(NREGS);
  localparam int FSW = fw_sel_width(NFWD);

  logic                     w_pending [NREGS];
  logic [LAT_W-1:0]         w_cnt     [NREGS];
  logic [AW-1:0]            w_issue_idx;
  logic [AW-1:0]            w_wb_idx;
  logic                     w_issue_eff;
  logic                     w_wb_eff;
  logic [NSRC-1:0]          w_haz;
  logic                     w_stall;
  logic [NSRC-1:0][FSW-1:0] w_fw_sel;
  logic [SCNT_W-1:0]        r_stall_cnt;

  // Address bits above the register-file index width are ignored.
  assign w_issue_idx = sb.issue_rd[AW-1:0];
  assign w_wb_idx    = sb.wb_rd[AW-1:0];

  assign w_issue_eff = sb.issue_valid & sb.issue_we & ~w_stall & ~sb.br_true
                     & (w_issue_idx != '0);
  assign w_wb_eff    = sb.wb_valid & (w_wb_idx != '0);

  generate
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
        assign w_pending[r] = 1'b0;
        assign w_cnt[r]     = '0;
      end else begin : g_entry
        hazard_sb_entry #(
          .LAT_W (LAT_W)
        ) u_entry (
          .clk     (clk),
          .rst     (rst),
          .load    (w_issue_eff && (w_issue_idx == AW'(r))),
          .clear   (w_wb_eff && (w_wb_idx == AW'(r))),
          .lat     (sb.issue_lat),
          .pending (w_pending[r]),
          .cnt     (w_cnt[r])
        );
      end
    end
  endgenerate

  always_comb begin
    w_haz = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_haz[i] = sb.src_valid[i]
               && (sb.src_addr[i][AW-1:0] != '0)
               && w_pending[sb.src_addr[i][AW-1:0]]
               && (w_cnt[sb.src_addr[i][AW-1:0]] != '0);
    end
  end

  // A taken branch squashes the stalled instruction, so it overrides the stall.
  assign w_stall = (|w_haz) & ~sb.br_true;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    w_fw_sel = '0;
    for (int i = 0; i < NSRC; i++) begin
      w_fw_sel[i] = FSW'(FW_SEL_RF);
      for (int k = NFWD - 1; k >= 0; k--) begin
        if (sb.fw_valid[k] && (sb.fw_rd[k] == sb.src_addr[i])
            && (sb.src_addr[i] != '0)) begin
          w_fw_sel[i] = FSW'(k + 1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + SCNT_W'(1);
    end
  end

  assign sb.stall     = w_stall;
  assign sb.bubble_ex = w_stall;
  assign sb.flush_if  = sb.br_true & ~rst;
  assign sb.flush_id  = sb.br_true & ~rst;
  assign sb.fw_sel    = w_fw_sel;
  assign sb.stall_cnt = r_stall_cnt;

endmodule : hazard_scoreboard
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Directed scoreboard bench for hazard_scoreboard.
// Rev    : 1.0
// ============================================================================
module tb_hazard_scoreboard;
  import hazard_scoreboard_pkg::*;

  localparam int NSRC   = 2;
  localparam int NFWD   = 2;
  localparam int LAT_W  = 4;
  localparam int SCNT_W = 32;

  localparam int S_STALL  = 0;
  localparam int S_BUBBLE = 1;
  localparam int S_FLIF   = 2;
  localparam int S_FLID   = 3;
  localparam int S_SEL0   = 4;
  localparam int S_SEL1   = 5;
  localparam int S_SCNT   = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_scoreboard_if #(
    .NSRC(NSRC), .NFWD(NFWD), .LAT_W(LAT_W), .SCNT_W(SCNT_W)
  ) sb ();

  hazard_scoreboard #(
    .NREGS(32), .NSRC(NSRC), .NFWD(NFWD), .LAT_W(LAT_W), .SCNT_W(SCNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] val;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      S_STALL:  return 64'(sb.stall);
      S_BUBBLE: return 64'(sb.bubble_ex);
      S_FLIF:   return 64'(sb.flush_if);
      S_FLID:   return 64'(sb.flush_id);
      S_SEL0:   return 64'(sb.fw_sel[0]);
      S_SEL1:   return 64'(sb.fw_sel[1]);
      default:  return 64'(sb.stall_cnt);
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic begin_cycle();
    @(negedge clk);
    sb.src_valid   = '0;
    sb.src_addr    = '0;
    sb.issue_valid = 1'b0;
    sb.issue_we    = 1'b0;
    sb.issue_rd    = '0;
    sb.issue_lat   = '0;
    sb.fw_valid    = '0;
    sb.fw_rd       = '0;
    sb.wb_valid    = 1'b0;
    sb.wb_rd       = '0;
    sb.br_true     = 1'b0;
  endtask

  task automatic end_cycle();
    exp_t e;
    #2;
    while (q.size() > 0) begin
      e = q.pop_front();
      check_val(e.tag, observe(e.sel), e.val);
    end
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
    sb.issue_valid = 1'b1;
    sb.issue_we    = 1'b1;
    sb.issue_rd    = rd;
    sb.issue_lat   = lat;
  endtask

  task automatic read0(input logic [4:0] a);
    sb.src_valid[0] = 1'b1;
    sb.src_addr[0]  = a;
  endtask

  initial begin
    // Reset: outputs quiet even with a branch present.
    begin_cycle(); sb.br_true = 1'b1; read0(5'd5);
    expect_out("rst_stall", S_STALL, 0); expect_out("rst_flif", S_FLIF, 0);
    expect_out("rst_flid", S_FLID, 0);   expect_out("rst_scnt", S_SCNT, 0);
    end_cycle();
    begin_cycle(); rst = 1'b0; end_cycle();

    // Load-use: lat 2 gives two stall cycles.
    begin_cycle(); issue(5'd5, 4'd2); expect_out("lu_issue_stall", S_STALL, 0); end_cycle();
    for (int c = 0; c < 3; c++) begin
      begin_cycle(); read0(5'd5); issue(5'd6, 4'd0);
      expect_out("lu_stall", S_STALL, (c < 2) ? 1 : 0);
      expect_out("lu_bubble", S_BUBBLE, (c < 2) ? 1 : 0);
      expect_out("lu_scnt", S_SCNT, c);
      end_cycle();
    end

    // ALU back-to-back plus per-stage selection.
    begin_cycle(); issue(5'd3, 4'd0); expect_out("alu_sel0_rf", S_SEL0, 0); end_cycle();
    begin_cycle(); read0(5'd3); sb.src_valid[1] = 1'b1; sb.src_addr[1] = 5'd8;
    sb.fw_valid = 2'b11; sb.fw_rd[0] = 5'd3; sb.fw_rd[1] = 5'd8;
    expect_out("alu_stall", S_STALL, 0); expect_out("alu_sel0", S_SEL0, 1);
    expect_out("alu_sel1", S_SEL1, 2);
    end_cycle();

    // Dual match: youngest stage wins.
    begin_cycle(); read0(5'd7); sb.src_valid[1] = 1'b1; sb.src_addr[1] = 5'd9;
    sb.fw_valid = 2'b11; sb.fw_rd[0] = 5'd7; sb.fw_rd[1] = 5'd7;
    expect_out("dual_sel0", S_SEL0, 1); expect_out("dual_sel1_nomatch", S_SEL1, 0);
    end_cycle();

    // x0 is never tracked nor forwarded.
    begin_cycle(); issue(5'd0, 4'd5); end_cycle();
    begin_cycle(); read0(5'd0); sb.fw_valid[0] = 1'b1; sb.fw_rd[0] = 5'd0;
    expect_out("x0_stall", S_STALL, 0); expect_out("x0_sel0", S_SEL0, 0);
    end_cycle();

    // Branch during a hazard overrides the stall; squashed issue is dropped.
    begin_cycle(); issue(5'd5, 4'd3); end_cycle();
    begin_cycle(); read0(5'd5); sb.br_true = 1'b1; issue(5'd10, 4'd4);
    expect_out("br_stall", S_STALL, 0); expect_out("br_bubble", S_BUBBLE, 0);
    expect_out("br_flif", S_FLIF, 1);   expect_out("br_flid", S_FLID, 1);
    end_cycle();
    begin_cycle(); read0(5'd10);
    expect_out("br_squash_nostall", S_STALL, 0); expect_out("br_flif_off", S_FLIF, 0);
    end_cycle();
    begin_cycle(); read0(5'd5);
    expect_out("br_resid_stall", S_STALL, 1); expect_out("br_scnt_a", S_SCNT, 2);
    end_cycle();
    begin_cycle(); read0(5'd5);
    expect_out("br_resid_done", S_STALL, 0); expect_out("br_scnt_b", S_SCNT, 3);
    end_cycle();
    begin_cycle(); sb.br_true = 1'b1; issue(5'd11, 4'd2); end_cycle();
    begin_cycle(); read0(5'd11); expect_out("br_noissue", S_STALL, 0); end_cycle();

    // Writeback clears a pending entry.
    begin_cycle(); issue(5'd12, 4'd6); end_cycle();
    begin_cycle(); sb.wb_valid = 1'b1; sb.wb_rd = 5'd12; end_cycle();
    begin_cycle(); read0(5'd12); expect_out("wb_clear", S_STALL, 0); end_cycle();

    // Max latency stalls.
    begin_cycle(); issue(5'd20, 4'd15); end_cycle();
    begin_cycle(); read0(5'd20); expect_out("lat_max_stall", S_STALL, 1); end_cycle();

    // Same-cycle writeback and issue: issue wins, then reset mid-count.
    begin_cycle(); issue(5'd9, 4'd3); sb.wb_valid = 1'b1; sb.wb_rd = 5'd9; end_cycle();
    begin_cycle(); read0(5'd9);
    expect_out("wbis_stall", S_STALL, 1); expect_out("wbis_scnt", S_SCNT, 4);
    end_cycle();
    begin_cycle(); rst = 1'b1; read0(5'd9); sb.br_true = 1'b1;
    expect_out("mid_rst_stall", S_STALL, 0); expect_out("mid_rst_scnt", S_SCNT, 0);
    expect_out("mid_rst_flif", S_FLIF, 0);
    end_cycle();
    begin_cycle(); rst = 1'b0; read0(5'd9);
    expect_out("post_rst_stall", S_STALL, 0); expect_out("post_rst_scnt", S_SCNT, 0);
    end_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_scoreboard
`default_nettype wire
